shift_register_reader: RTL and testbench
========================================

SHIFT_REGISTER_READER -- requirements
Module: shift_register_reader

Interface
REQ-001 Parameter WIDTH, default 8: number of bits read per transfer; legal range 1..32.
REQ-002 Parameter CLK_DIV, default 4: clk cycles per load, settle, high and low phase; legal range 3..255.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request one parallel-load-and-read transfer; synchronous to clk.
REQ-006 serial_in  input  1  serial data from the external parallel-in/serial-out register (Q7 pin); asynchronous.
REQ-007 load_n  output  1  active-low parallel-load strobe to the external register.
REQ-008 shift_clk  output  1  shift clock to the external register.
REQ-009 data_out  output  WIDTH  last completed word, MSB = first bit read.
REQ-010 data_valid  output  1  one-cycle pulse when data_out updates.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 load_n, shift_clk, data_valid and busy SHALL be driven directly from flops, with no combinational glitches.
REQ-013 serial_in SHALL pass through a 2-flop synchronizer before use; all sampling uses the synchronized value.
REQ-014 FSM states SHALL be IDLE, LOAD, SETTLE, HIGH, LOW and DONE.
REQ-015 IDLE: load_n=1, shift_clk=0, busy=0; start=1 -> LOAD, phase counter and bit counter cleared.
REQ-016 LOAD: load_n=0 for exactly CLK_DIV cycles -> SETTLE.
REQ-017 SETTLE: load_n=1 for CLK_DIV cycles; on the last cycle, sample the first bit and set bit_cnt=1; WIDTH==1 -> DONE, else HIGH.
REQ-018 HIGH: shift_clk=1 for CLK_DIV cycles -> LOW.
REQ-019 LOW: shift_clk=0 for CLK_DIV cycles; on the last cycle, sample a bit and increment bit_cnt; bit_cnt reaching WIDTH -> DONE, else HIGH.
REQ-020 Sampling SHALL shift left: sr <= {sr[WIDTH-2:0], bit}, so the first bit lands in data_out[WIDTH-1].
REQ-021 DONE: data_out <= sr and data_valid=1 for exactly one cycle, busy=1 -> IDLE.
REQ-022 Exactly WIDTH-1 shift_clk rising edges SHALL occur per transfer.
REQ-023 data_valid SHALL be high in the cycle 2*CLK_DIV*WIDTH+1 clk cycles after the edge that accepted start (65 for the defaults).
REQ-024 start while busy=1, including in the DONE cycle, SHALL be ignored and not queued.
REQ-025 start held high continuously SHALL begin a new transfer on the first IDLE cycle after DONE, with back-to-back reads and no gap beyond that cycle.
REQ-026 data_out SHALL hold its value between DONE cycles; a partial transfer SHALL never modify it.

Reset
REQ-027 Reset SHALL set state=IDLE, load_n=1, shift_clk=0, data_valid=0, busy=0, data_out=0, the shift register, counters and synchronizer to 0.
REQ-028 Reset asserted mid-transfer SHALL abort immediately: no data_valid pulse, and outputs reach their reset values without waiting for a clk edge.
REQ-029 After reset deasserts, the first transfer SHALL behave identically to a transfer from a fresh power-up.

Structure
REQ-030 Shared package dark_tower_pkg SHALL hold the FSM state encoding and the default WIDTH and CLK_DIV constants.
REQ-031 The 2-flop synchronizer SHALL be a separate sub-module, sync_2ff (clk, reset, d, q), reusable for other asynchronous inputs.
REQ-032 The phase counter and bit counter SHALL be widths derived from CLK_DIV and WIDTH with no truncation at the maximum legal values.

Verification
REQ-033 Defaults, external register model loaded with 8'hA5, single start pulse -> load_n low 4 cycles; 7 shift_clk pulses; data_valid at cycle 65; data_out=8'hA5.
REQ-034 Model value 8'h3C, start pulsed again at cycles 10 and 40 -> those pulses ignored; exactly one data_valid; data_out=8'h3C.
REQ-035 start held high, model values 8'hFF then 8'h00 -> two data_valid pulses 66 cycles apart; data_out=8'hFF then 8'h00.
REQ-036 Reset asserted at cycle 30 of a transfer of 8'h5A (prior data_out=8'hA5) -> outputs at reset values immediately; no data_valid; data_out=0.
REQ-037 WIDTH=1, CLK_DIV=3, model bit 1 -> no shift_clk edges; data_valid at cycle 7; data_out=1'b1.
REQ-038 WIDTH=16, model 16'h8001 -> 15 shift_clk rising edges; data_valid at cycle 129; data_out=16'h8001.

Source files
------------

// File: rtl/dark_tower_pkg.sv
// Shared definitions for the shift-register reader: FSM encoding, default
// geometry, and a helper for sizing counters that must hold their maximum value.
package dark_tower_pkg;

    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_CLK_DIV = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_HIGH   = 3'd3,
        ST_LOW    = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Bits needed to represent every value in 0..max_val inclusive.
    function automatic int cnt_bits(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; q lags d by two clk edges.
// Reset clears both stages so a fresh start never sees stale metastable state.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/shift_register_reader.sv
// Reads WIDTH bits from an external parallel-in/serial-out register: pulse load_n,
// then clock out the bits MSB first; one transfer takes 2*CLK_DIV*WIDTH+1 cycles.
module shift_register_reader
    import dark_tower_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             serial_in,
    output logic             load_n,
    output logic             shift_clk,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             busy
);

    localparam int PH_W = cnt_bits(CLK_DIV);
    localparam int BC_W = cnt_bits(WIDTH);

    state_t            state_q, state_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic [WIDTH-1:0]  data_out_q, data_out_d;
    logic              load_n_q, shift_clk_q, data_valid_q, busy_q;

    logic              serial_s;
    logic              ph_last;
    logic [WIDTH-1:0]  sr_shift;
    logic [BC_W-1:0]   bit_cnt_inc;

    sync_2ff u_sync_serial (
        .clk   (clk),
        .reset (reset),
        .d     (serial_in),
        .q     (serial_s)
    );

    assign ph_last     = (ph_q == PH_W'(CLK_DIV - 1));
    assign sr_shift    = (sr_q << 1) | WIDTH'(serial_s);
    assign bit_cnt_inc = bit_cnt_q + BC_W'(1);

    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        bit_cnt_d  = bit_cnt_q;
        sr_d       = sr_q;
        data_out_d = data_out_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    ph_d      = '0;
                    bit_cnt_d = '0;
                end
            end
            ST_LOAD: begin
                if (ph_last) begin
                    state_d = ST_SETTLE;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            ST_SETTLE: begin
                if (ph_last) begin
                    ph_d      = '0;
                    sr_d      = sr_shift;
                    bit_cnt_d = BC_W'(1);
                    if (WIDTH == 1) begin
                        state_d    = ST_DONE;
                        data_out_d = sr_shift;
                    end else begin
                        state_d = ST_HIGH;
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            ST_HIGH: begin
                if (ph_last) begin
                    state_d = ST_LOW;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            ST_LOW: begin
                if (ph_last) begin
                    ph_d      = '0;
                    sr_d      = sr_shift;
                    bit_cnt_d = bit_cnt_inc;
                    // Publish the word on entry to DONE so it is stable while data_valid is high.
                    if (bit_cnt_inc == BC_W'(WIDTH)) begin
                        state_d    = ST_DONE;
                        data_out_d = sr_shift;
                    end else begin
                        state_d = ST_HIGH;
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes are registered from the next state so each output tracks its state exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ph_q         <= '0;
            bit_cnt_q    <= '0;
            sr_q         <= '0;
            data_out_q   <= '0;
            load_n_q     <= 1'b1;
            shift_clk_q  <= 1'b0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            bit_cnt_q    <= bit_cnt_d;
            sr_q         <= sr_d;
            data_out_q   <= data_out_d;
            load_n_q     <= (state_d != ST_LOAD);
            shift_clk_q  <= (state_d == ST_HIGH);
            data_valid_q <= (state_d == ST_DONE);
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    assign load_n     = load_n_q;
    assign shift_clk  = shift_clk_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_shift_register_reader.sv
// Bench for shift_register_reader: three geometries, each fed by a behavioural
// parallel-in/serial-out register model, checked against arithmetic expectations.
module tb_shift_register_reader;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        start0, start1, start2;
    logic        ld_n0, ld_n1, ld_n2, sck0, sck1, sck2;
    logic        dv0, dv1, dv2, bsy0, bsy1, bsy2;
    logic [7:0]  d0;
    logic [0:0]  d1;
    logic [15:0] d2;
    logic [31:0] ext_val0 = '0, ext_val1 = '0, ext_val2 = '0;
    logic [31:0] ext_q0 = '0, ext_q1 = '0, ext_q2 = '0;

    // External register models: parallel load while load_n low, shift toward MSB on shift_clk rise.
    always @(negedge ld_n0 or posedge sck0) if (!ld_n0) ext_q0 = ext_val0; else ext_q0 = ext_q0 << 1;
    always @(negedge ld_n1 or posedge sck1) if (!ld_n1) ext_q1 = ext_val1; else ext_q1 = ext_q1 << 1;
    always @(negedge ld_n2 or posedge sck2) if (!ld_n2) ext_q2 = ext_val2; else ext_q2 = ext_q2 << 1;

    shift_register_reader u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .serial_in(ext_q0[7]),
        .load_n(ld_n0), .shift_clk(sck0), .data_out(d0), .data_valid(dv0), .busy(bsy0)
    );
    shift_register_reader #(.WIDTH(1), .CLK_DIV(3)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .serial_in(ext_q1[0]),
        .load_n(ld_n1), .shift_clk(sck1), .data_out(d1), .data_valid(dv1), .busy(bsy1)
    );
    shift_register_reader #(.WIDTH(16), .CLK_DIV(4)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .serial_in(ext_q2[15]),
        .load_n(ld_n2), .shift_clk(sck2), .data_out(d2), .data_valid(dv2), .busy(bsy2)
    );

    function automatic int wid_of(input int inst);
        return (inst == 0) ? 8 : (inst == 1) ? 1 : 16;
    endfunction
    function automatic int cdiv_of(input int inst);
        return (inst == 1) ? 3 : 4;
    endfunction
    function automatic logic [31:0] mask_of(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction
    // Reference timing: load + settle, then one high/low pair per remaining bit, then DONE.
    function automatic int exp_vcyc(input int inst);
        return 2 * cdiv_of(inst) * wid_of(inst) + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_start(input int inst, input logic v);
        case (inst)
            0: start0 = v;
            1: start1 = v;
            default: start2 = v;
        endcase
    endtask

    task automatic set_ext(input int inst, input logic [31:0] v);
        case (inst)
            0: ext_val0 = v;
            1: ext_val1 = v;
            default: ext_val2 = v;
        endcase
    endtask

    task automatic sample(input int inst, output logic l, output logic s, output logic v,
                          output logic b, output logic [31:0] d);
        case (inst)
            0: begin l = ld_n0; s = sck0; v = dv0; b = bsy0; d = {24'b0, d0}; end
            1: begin l = ld_n1; s = sck1; v = dv1; b = bsy1; d = {31'b0, d1}; end
            default: begin l = ld_n2; s = sck2; v = dv2; b = bsy2; d = {16'b0, d2}; end
        endcase
    endtask

    // One transfer; extra start pulses are raised in cycles ign_a/ign_b (cycle 1 follows the accepting edge).
    task automatic xfer(input int inst, input logic [31:0] val, input int ign_a, input int ign_b,
                        output int vcyc, output int ld_low, output int edges, output int nvalid,
                        output logic [31:0] vdat, output int hold_err, output logic busy_end);
        logic l, s, v, b, prev_s;
        logic [31:0] d, d_before;
        int cyc;
        vcyc = 0; ld_low = 0; edges = 0; nvalid = 0; vdat = '0; hold_err = 0; cyc = 0;
        set_ext(inst, val);
        @(negedge clk);
        sample(inst, l, prev_s, v, b, d_before);
        set_start(inst, 1'b1);
        while (cyc < 4000) begin
            @(negedge clk);
            cyc++;
            set_start(inst, (cyc == ign_a) || (cyc == ign_b));
            sample(inst, l, s, v, b, d);
            if (!l) ld_low++;
            if (s && !prev_s) edges++;
            prev_s = s;
            if (v) begin
                nvalid++;
                vcyc = cyc;
                vdat = d;
            end else if (nvalid == 0 && d !== d_before) begin
                hold_err++;
            end
            if (nvalid > 0 && cyc >= vcyc + 3) break;
        end
        busy_end = b;
    endtask

    typedef struct {
        int          inst;
        logic [31:0] val;
        int          ign_a;
        int          ign_b;
        logic [31:0] exp_dat;
        int          exp_cyc;
        int          exp_edges;
    } vec_t;

    vec_t tbl[7];

    task automatic run_and_check(input string tag, input int inst, input logic [31:0] val,
                                 input int ign_a, input int ign_b, input logic [31:0] exp_dat,
                                 input int exp_cyc, input int exp_edges);
        int vcyc, ld_low, edges, nvalid, hold_err;
        logic [31:0] vdat;
        logic busy_end;
        xfer(inst, val, ign_a, ign_b, vcyc, ld_low, edges, nvalid, vdat, hold_err, busy_end);
        chk({tag, "_nvalid"}, nvalid, 1);
        chk({tag, "_vcyc"}, vcyc, exp_cyc);
        chk({tag, "_data"}, vdat, exp_dat);
        chk({tag, "_edges"}, edges, exp_edges);
        chk({tag, "_load_cycles"}, ld_low, cdiv_of(inst));
        chk({tag, "_hold"}, hold_err, 0);
        chk({tag, "_idle_after"}, {31'b0, busy_end}, 0);
    endtask

    initial begin
        logic l, s, v, b;
        logic [31:0] d;
        int vq[$];
        logic [31:0] dq[$];
        int cyc, dv_in_reset;

        reset = 1'b1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sample(i, l, s, v, b, d);
            chk($sformatf("rst%0d_outs", i), {27'b0, l, s, v, b, 1'b0}, {27'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
            chk($sformatf("rst%0d_dout", i), d, 0);
        end
        reset = 1'b0;

        tbl[0] = '{0, 32'hA5,   0,   0, 32'hA5,   65,  7};
        tbl[1] = '{0, 32'h3C,   10,  40, 32'h3C,  65,  7};
        tbl[2] = '{1, 32'h1,    0,   0, 32'h1,    7,   0};
        tbl[3] = '{2, 32'h8001, 0,   0, 32'h8001, 129, 15};
        tbl[4] = '{0, 32'h5A,   1,   65, 32'h5A,  65,  7};
        tbl[5] = '{1, 32'h0,    7,   0, 32'h0,    7,   0};
        tbl[6] = '{2, 32'hF00F, 64,  129, 32'hF00F, 129, 15};
        for (int i = 0; i < 7; i++)
            run_and_check($sformatf("vec%0d", i), tbl[i].inst, tbl[i].val, tbl[i].ign_a,
                          tbl[i].ign_b, tbl[i].exp_dat, tbl[i].exp_cyc, tbl[i].exp_edges);

        // start held high: back-to-back transfers, model value swapped after the first word.
        set_ext(0, 32'hFF);
        @(negedge clk);
        start0 = 1'b1;
        cyc = 0;
        while (cyc < 400 && vq.size() < 2) begin
            @(negedge clk);
            cyc++;
            if (dv0) begin
                vq.push_back(cyc);
                dq.push_back({24'b0, d0});
                set_ext(0, 32'h00);
                if (vq.size() == 2) start0 = 1'b0;
            end
        end
        start0 = 1'b0;
        chk("held_npulses", vq.size(), 2);
        if (vq.size() == 2) begin
            chk("held_gap", vq[1] - vq[0], exp_vcyc(0) + 1);
            chk("held_first", dq[0], 32'hFF);
            chk("held_second", dq[1], 32'h00);
        end
        repeat (4) @(negedge clk);
        chk("held_idle_after", {31'b0, bsy0}, 0);

        // Reset mid-transfer: prior word A5, abort a read of 5A at cycle 30.
        run_and_check("pre_rst", 0, 32'hA5, 0, 0, 32'hA5, 65, 7);
        set_ext(0, 32'h5A);
        @(negedge clk);
        start0 = 1'b1;
        dv_in_reset = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start0 = 1'b0;
            if (dv0) dv_in_reset++;
        end
        chk("midrst_busy_before", {31'b0, bsy0}, 1);
        #1 reset = 1'b1;
        #1;
        chk("midrst_outs", {28'b0, ld_n0, sck0, dv0, bsy0}, {28'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        chk("midrst_dout", {24'b0, d0}, 0);
        repeat (3) begin
            @(negedge clk);
            if (dv0) dv_in_reset++;
        end
        reset = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (dv0) dv_in_reset++;
        end
        chk("midrst_no_valid", dv_in_reset, 0);
        chk("midrst_dout_after", {24'b0, d0}, 0);
        run_and_check("post_rst", 0, 32'h5A, 0, 0, 32'h5A, 65, 7);

        // Randomised transfers on every geometry with stray start pulses while busy.
        for (int n = 0; n < 18; n++) begin
            int inst;
            logic [31:0] val;
            inst = n % 3;
            val = $urandom;
            run_and_check($sformatf("rnd%0d", n), inst, val,
                          $urandom_range(1, exp_vcyc(inst)), $urandom_range(1, exp_vcyc(inst)),
                          val & mask_of(wid_of(inst)), exp_vcyc(inst), wid_of(inst) - 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
